// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding, approach indices and counter sizing helpers
// for the intersection signal blocks. FLASH exists only when NIGHT_FLASH_EN is defined.
package traffic_pkg;

   typedef enum logic [2:0] {
      A_GREEN,
      A_YELLOW,
      ALLRED_AB,
      B_GREEN,
      B_YELLOW,
      ALLRED_BA
`ifdef NIGHT_FLASH_EN
      , FLASH
`endif
   } state_t;

   localparam logic APP_A = 1'b0;
   localparam logic APP_B = 1'b1;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Width of a counter holding 0..max_sec-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_sec);
      return (max_sec > 1) ? $clog2(max_sec) : 1;
   endfunction

endpackage

// File: rtl/sec_timebase.sv
// sec_timebase: clk prescaler producing a one-cycle tick per second, plus a
// saturating count of elapsed seconds; both clear synchronously on clear.
module sec_timebase
   import traffic_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 50_000_000,
   parameter int unsigned MAX_SEC       = 10
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              clear,
   output logic                              sec_tick,
   output logic [cnt_width(MAX_SEC)-1:0]     sec_cnt
);

   localparam int unsigned PW = $clog2(TICKS_PER_SEC);
   localparam int unsigned CW = cnt_width(MAX_SEC);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(MAX_SEC - 1);

   logic [PW-1:0] presc;

   assign sec_tick = (presc == PRESC_LAST);

   // Saturation keeps open-ended states (night flash) from wrapping the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc   <= '0;
         sec_cnt <= '0;
      end else if (clear) begin
         presc   <= '0;
         sec_cnt <= '0;
      end else begin
         presc <= sec_tick ? '0 : presc + 1'b1;
         if (sec_tick && (sec_cnt != CNT_LAST))
            sec_cnt <= sec_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: two-approach sequencer with pedestrian latching and a
// priority early green cut. Define NIGHT_FLASH_EN to add night_mode / FLASH.
module intersection_scheduler
   import traffic_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC  = 50_000_000,
   parameter int unsigned GREEN_SEC      = 10,
   parameter int unsigned YELLOW_SEC     = 1,
   parameter int unsigned ALLRED_SEC     = 1,
   parameter int unsigned MIN_GREEN_SEC  = 3,
   parameter int unsigned START_APPROACH = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ped_req_a,
   input  logic       ped_req_b,
   input  logic       ped_priority,
`ifdef NIGHT_FLASH_EN
   input  logic       night_mode,
`endif
   output logic       red_a,
   output logic       yellow_a,
   output logic       green_a,
   output logic       red_b,
   output logic       yellow_b,
   output logic       green_b,
   output logic       walk_a,
   output logic       walk_b,
   output logic [1:0] ped_pending,
   output logic       sec_tick
);

   localparam int unsigned MAX_SEC = max3(GREEN_SEC, YELLOW_SEC, ALLRED_SEC);
   localparam int unsigned CW      = cnt_width(MAX_SEC);
   localparam logic [CW-1:0] GREEN_LAST  = CW'(GREEN_SEC - 1);
   localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_SEC - 1);
   localparam logic [CW-1:0] ALLRED_LAST = CW'(ALLRED_SEC - 1);
   localparam logic [CW-1:0] MIN_LAST    = CW'(MIN_GREEN_SEC - 1);
   localparam state_t RESET_STATE = (START_APPROACH != 0) ? B_GREEN : A_GREEN;

   state_t        state_q, state_d;
   logic [CW-1:0] sec_cnt;
   logic          tick, trans, enter_a, enter_b, cut_a, cut_b;
   logic [1:0]    pend_q, pend_d;
   logic          served_a_q, served_b_q;
`ifdef NIGHT_FLASH_EN
   logic          flash_on_q;
`endif

   sec_timebase #(.TICKS_PER_SEC(TICKS_PER_SEC), .MAX_SEC(MAX_SEC)) u_timebase (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (trans),
      .sec_tick(tick),
      .sec_cnt (sec_cnt)
   );

   assign sec_tick    = tick;
   assign ped_pending = pend_q;
   assign trans       = (state_d != state_q);
   assign enter_a     = trans && (state_d == A_GREEN);
   assign enter_b     = trans && (state_d == B_GREEN);
   assign cut_a       = ped_priority && pend_q[APP_B] && (sec_cnt >= MIN_LAST);
   assign cut_b       = ped_priority && pend_q[APP_A] && (sec_cnt >= MIN_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         A_GREEN:   if (tick && ((sec_cnt == GREEN_LAST) || cut_a)) state_d = A_YELLOW;
         A_YELLOW:  if (tick && (sec_cnt == YELLOW_LAST)) state_d = ALLRED_AB;
         ALLRED_AB: if (tick && (sec_cnt == ALLRED_LAST)) begin
`ifdef NIGHT_FLASH_EN
            state_d = night_mode ? FLASH : B_GREEN;
`else
            state_d = B_GREEN;
`endif
         end
         B_GREEN:   if (tick && ((sec_cnt == GREEN_LAST) || cut_b)) state_d = B_YELLOW;
         B_YELLOW:  if (tick && (sec_cnt == YELLOW_LAST)) state_d = ALLRED_BA;
         ALLRED_BA: if (tick && (sec_cnt == ALLRED_LAST)) begin
`ifdef NIGHT_FLASH_EN
            state_d = night_mode ? FLASH : A_GREEN;
`else
            state_d = A_GREEN;
`endif
         end
`ifdef NIGHT_FLASH_EN
         FLASH:     if (tick && !night_mode) state_d = ALLRED_BA;
`endif
         default:   state_d = RESET_STATE;
      endcase
   end

   // A request arriving on the entry edge survives the clear and is served next round.
   always_comb begin
      pend_d        = pend_q;
      pend_d[APP_A] = ped_req_a | (pend_q[APP_A] & ~enter_a);
      pend_d[APP_B] = ped_req_b | (pend_q[APP_B] & ~enter_b);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RESET_STATE;
         pend_q     <= '0;
         served_a_q <= 1'b0;
         served_b_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         if (enter_a)    served_a_q <= pend_q[APP_A];
         else if (trans) served_a_q <= 1'b0;
         if (enter_b)    served_b_q <= pend_q[APP_B];
         else if (trans) served_b_q <= 1'b0;
      end
   end

`ifdef NIGHT_FLASH_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         flash_on_q <= 1'b0;
      else if (trans && (state_d == FLASH))
         flash_on_q <= 1'b1;
      else if ((state_q == FLASH) && tick)
         flash_on_q <= ~flash_on_q;
   end
`endif

   always_comb begin
      red_a    = 1'b0;
      yellow_a = 1'b0;
      green_a  = 1'b0;
      red_b    = 1'b0;
      yellow_b = 1'b0;
      green_b  = 1'b0;
      walk_a   = 1'b0;
      walk_b   = 1'b0;
      case (state_q)
         A_GREEN:  begin green_a  = 1'b1; red_b = 1'b1; walk_a = served_a_q; end
         A_YELLOW: begin yellow_a = 1'b1; red_b = 1'b1; end
         B_GREEN:  begin green_b  = 1'b1; red_a = 1'b1; walk_b = served_b_q; end
         B_YELLOW: begin yellow_b = 1'b1; red_a = 1'b1; end
`ifdef NIGHT_FLASH_EN
         FLASH:    begin yellow_a = flash_on_q; yellow_b = flash_on_q; end
`endif
         default:  begin red_a = 1'b1; red_b = 1'b1; end
      endcase
   end

endmodule
